// File: rtl/pkt_tx_acceptor_if.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_tx_acceptor_if
//  Description : Packet TX input stream plus buffered head-word handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface pkt_tx_acceptor_if;
    logic        pkt_tx_val;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_full;

    logic        out_val;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_mod;
    logic [63:0] out_data;
    logic        out_err;
    logic        out_rdy;

    modport slave (
        input  pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data, out_rdy,
        output pkt_tx_full, out_val, out_sop, out_eop, out_mod, out_data, out_err
    );

    modport master (
        output pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data, out_rdy,
        input  pkt_tx_full, out_val, out_sop, out_eop, out_mod, out_data, out_err
    );
endinterface
`default_nettype wire

// File: rtl/pkt_tx_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_tx_acceptor
//  Description : Framing checker, FWFT word FIFO and back-pressure for the
//                64-bit packet TX interface, with frame/drop counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pkt_tx_acceptor #(
    parameter int DEPTH       = 16,
    parameter int FULL_THRESH = 12
) (
    input  wire               clk_156m25,
    input  wire               reset_156m25,
    pkt_tx_acceptor_if.slave  bus,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int WW = 70;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_IN_FRAME = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            pend_err_q, pend_err_d;
    logic            full_q, full_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [WW-1:0]   mem_q [DEPTH];

    logic            accept;
    logic            stray;
    logic            push;
    logic            pop;
    logic            overflow;
    logic            in_frame;
    logic [WW-1:0]   wr_word;
    logic [WW-1:0]   head;
    logic            head_val;

    always_comb begin
        in_frame    = (state_q == S_IN_FRAME);
        accept      = bus.pkt_tx_val & (in_frame | bus.pkt_tx_sop);
        stray       = bus.pkt_tx_val & ~in_frame & ~bus.pkt_tx_sop;
        overflow    = accept & (occ_q == OW'(DEPTH));
        push        = accept & ~overflow;
        head_val    = (occ_q != '0);
        pop         = head_val & bus.out_rdy;

        // A sop inside a frame is demoted to a tagged continuation word.
        wr_word     = {pend_err_q | (in_frame & bus.pkt_tx_sop),
                       bus.pkt_tx_sop & ~in_frame,
                       bus.pkt_tx_eop,
                       bus.pkt_tx_eop ? bus.pkt_tx_mod : 3'd0,
                       bus.pkt_tx_data};

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        pend_err_d  = pend_err_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        // Overflowed words still advance framing so later words stay aligned.
        if (accept) begin
            state_d = bus.pkt_tx_eop ? S_IDLE : S_IN_FRAME;
        end

        if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            pend_err_d = 1'b0;
            if (bus.pkt_tx_eop) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end else if (overflow) begin
            pend_err_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OW'(1);
        end

        if ((stray || overflow) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        full_d = (occ_d >= OW'(FULL_THRESH));
    end

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            pend_err_q  <= 1'b0;
            full_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            pend_err_q  <= pend_err_d;
            full_q      <= full_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by the occupancy counter.
    always_ff @(posedge clk_156m25) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign bus.out_val     = head_val;
    assign bus.out_err     = head_val & head[69];
    assign bus.out_sop     = head_val & head[68];
    assign bus.out_eop     = head_val & head[67];
    assign bus.out_mod     = head_val ? head[66:64] : 3'd0;
    assign bus.out_data    = head_val ? head[63:0] : 64'd0;
    assign bus.pkt_tx_full = full_q;
    assign frame_cnt       = frame_cnt_q;
    assign drop_cnt        = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_tx_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_tx_acceptor
//  Description : Directed bench with a queue-based reference model for
//                pkt_tx_acceptor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pkt_tx_acceptor;

    localparam int DEPTH       = 16;
    localparam int FULL_THRESH = 12;

    typedef struct packed {
        logic        err;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic [63:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pkt_tx_acceptor_if bus_if ();

    pkt_tx_acceptor #(
        .DEPTH       (DEPTH),
        .FULL_THRESH (FULL_THRESH)
    ) dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .bus          (bus_if),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus framing/counter state.
    word_t m_q[$];
    bit    m_in_frame, m_pend, m_full;
    int    m_frame, m_drop;
    int    m_occ;
    word_t m_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_in_frame = 0; m_pend = 0; m_full = 0;
            m_frame = 0;    m_drop = 0;
        end else begin
            m_occ = m_q.size();
            if (m_occ != 0 && bus_if.out_rdy) void'(m_q.pop_front());
            if (bus_if.pkt_tx_val) begin
                if (!m_in_frame && !bus_if.pkt_tx_sop) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_w.err  = m_pend || (m_in_frame && bus_if.pkt_tx_sop);
                    m_w.sop  = bus_if.pkt_tx_sop && !m_in_frame;
                    m_w.eop  = bus_if.pkt_tx_eop;
                    m_w.mod  = bus_if.pkt_tx_eop ? bus_if.pkt_tx_mod : 3'd0;
                    m_w.data = bus_if.pkt_tx_data;
                    if (m_occ == DEPTH) begin
                        if (m_drop < 65535) m_drop++;
                        m_pend = 1;
                    end else begin
                        m_q.push_back(m_w);
                        m_pend = 0;
                        if (bus_if.pkt_tx_eop) m_frame = (m_frame + 1) % 65536;
                    end
                    m_in_frame = !bus_if.pkt_tx_eop;
                end
            end
            m_full = (m_q.size() >= FULL_THRESH);
        end
    end

    always @(negedge clk) begin
        check("out_val", {63'd0, bus_if.out_val}, {63'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check("out_data", bus_if.out_data, m_q[0].data);
            check("out_sop", {63'd0, bus_if.out_sop}, {63'd0, m_q[0].sop});
            check("out_eop", {63'd0, bus_if.out_eop}, {63'd0, m_q[0].eop});
            check("out_mod", {61'd0, bus_if.out_mod}, {61'd0, m_q[0].mod});
            check("out_err", {63'd0, bus_if.out_err}, {63'd0, m_q[0].err});
        end
        check("pkt_tx_full", {63'd0, bus_if.pkt_tx_full}, {63'd0, m_full});
        check("frame_cnt", {48'd0, frame_cnt}, 64'(m_frame));
        check("drop_cnt", {48'd0, drop_cnt}, 64'(m_drop));
    end

    task automatic drive(input logic sop, input logic eop, input logic [2:0] mod,
                         input logic [63:0] data);
        bus_if.pkt_tx_val  = 1'b1;
        bus_if.pkt_tx_sop  = sop;
        bus_if.pkt_tx_eop  = eop;
        bus_if.pkt_tx_mod  = mod;
        bus_if.pkt_tx_data = data;
        @(posedge clk); #1;
        bus_if.pkt_tx_val  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_if.pkt_tx_val = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        bus_if.out_rdy = 1'b1;
        for (int i = 0; i < 40 && bus_if.out_val; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_drained"}, {63'd0, bus_if.out_val}, 64'd0);
    endtask

    logic [63:0] t2_data [4];
    bit          seen;

    initial begin
        rst = 1'b1;
        bus_if.pkt_tx_val  = 1'b0;
        bus_if.pkt_tx_sop  = 1'b0;
        bus_if.pkt_tx_eop  = 1'b0;
        bus_if.pkt_tx_mod  = 3'd0;
        bus_if.pkt_tx_data = 64'd0;
        bus_if.out_rdy     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_val", {63'd0, bus_if.out_val}, 64'd0);
        check("rst_out_err", {63'd0, bus_if.out_err}, 64'd0);
        check("rst_full", {63'd0, bus_if.pkt_tx_full}, 64'd0);
        check("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
        check("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        rst = 1'b0;
        idle(2);

        // Single-word frame
        bus_if.out_rdy = 1'b1;
        drive(1'b1, 1'b1, 3'd5, 64'h1122334455667788);
        check("t1_val", {63'd0, bus_if.out_val}, 64'd1);
        check("t1_data", bus_if.out_data, 64'h1122334455667788);
        check("t1_sop_eop", {62'd0, bus_if.out_sop, bus_if.out_eop}, 64'd3);
        check("t1_mod", {61'd0, bus_if.out_mod}, 64'd5);
        check("t1_err", {63'd0, bus_if.out_err}, 64'd0);
        check("t1_frame_cnt", {48'd0, frame_cnt}, 64'd1);
        idle(1);
        check("t1_popped", {63'd0, bus_if.out_val}, 64'd0);

        // Four-word frame held, then released
        bus_if.out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) t2_data[i] = 64'hA000_0000_0000_0000 + 64'(i);
        for (int i = 0; i < 4; i++) drive(i == 0, i == 3, (i == 3) ? 3'd0 : 3'd6, t2_data[i]);
        check("t2_full", {63'd0, bus_if.pkt_tx_full}, 64'd0);
        check("t2_frame_cnt", {48'd0, frame_cnt}, 64'd2);
        bus_if.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_order", bus_if.out_data, t2_data[i]);
            check("t2_eop", {63'd0, bus_if.out_eop}, (i == 3) ? 64'd1 : 64'd0);
            check("t2_mod", {61'd0, bus_if.out_mod}, 64'd0);
            @(posedge clk); #1;
        end
        check("t2_empty", {63'd0, bus_if.out_val}, 64'd0);

        // Fill to overflow
        bus_if.out_rdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(i == 0, 1'b0, 3'd0, 64'hC000_0000_0000_0000 + 64'(i));
            if (i == 10) check("t3_full_11", {63'd0, bus_if.pkt_tx_full}, 64'd0);
            if (i == 11) check("t3_full_12", {63'd0, bus_if.pkt_tx_full}, 64'd1);
            if (i == 15) check("t3_nodrop_16", {48'd0, drop_cnt}, 64'd0);
        end
        check("t3_drop_17", {48'd0, drop_cnt}, 64'd1);
        bus_if.out_rdy = 1'b1;
        idle(1);
        bus_if.out_rdy = 1'b0;
        drive(1'b0, 1'b1, 3'd3, 64'hDEAD_BEEF_0000_0012);
        check("t3_full_after", {63'd0, bus_if.pkt_tx_full}, 64'd1);
        check("t3_frame_cnt", {48'd0, frame_cnt}, 64'd3);
        bus_if.out_rdy = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && bus_if.out_val; i++) begin
            if (bus_if.out_eop) begin
                seen = 1;
                check("t3_err_word", {63'd0, bus_if.out_err}, 64'd1);
                check("t3_err_data", bus_if.out_data, 64'hDEAD_BEEF_0000_0012);
                check("t3_err_mod", {61'd0, bus_if.out_mod}, 64'd3);
            end
            @(posedge clk); #1;
        end
        check("t3_eop_seen", {63'd0, seen}, 64'd1);
        check("t3_drained", {63'd0, bus_if.out_val}, 64'd0);

        // Framing errors: stray word, then sop, data, sop, eop
        bus_if.out_rdy = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 64'h5555);
        check("t4_stray_drop", {48'd0, drop_cnt}, 64'd2);
        check("t4_stray_nowrite", {63'd0, bus_if.out_val}, 64'd0);
        drive(1'b1, 1'b0, 3'd0, 64'h4000);
        drive(1'b0, 1'b0, 3'd0, 64'h4001);
        drive(1'b1, 1'b0, 3'd0, 64'h4002);
        drive(1'b0, 1'b1, 3'd2, 64'h4003);
        check("t4_frame_cnt", {48'd0, frame_cnt}, 64'd4);
        bus_if.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_data", bus_if.out_data, 64'h4000 + 64'(i));
            check("t4_sop", {63'd0, bus_if.out_sop}, (i == 0) ? 64'd1 : 64'd0);
            check("t4_err", {63'd0, bus_if.out_err}, (i == 2) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
        end
        check("t4_empty", {63'd0, bus_if.out_val}, 64'd0);

        // Push and pop together at the threshold
        bus_if.out_rdy = 1'b0;
        for (int i = 0; i < 12; i++) drive(i == 0, 1'b0, 3'd0, 64'hE000 + 64'(i));
        check("t5_full_12", {63'd0, bus_if.pkt_tx_full}, 64'd1);
        bus_if.out_rdy = 1'b1;
        drive(1'b0, 1'b1, 3'd7, 64'hE00C);
        check("t5_full_pushpop", {63'd0, bus_if.pkt_tx_full}, 64'd1);
        idle(1);
        check("t5_full_poponly", {63'd0, bus_if.pkt_tx_full}, 64'd0);
        drain("t5");

        // Reset mid-frame
        bus_if.out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) drive(i == 0, 1'b0, 3'd0, 64'hF000 + 64'(i));
        check("t6_buffered", {63'd0, bus_if.out_val}, 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_val", {63'd0, bus_if.out_val}, 64'd0);
        check("t6_rst_frame", {48'd0, frame_cnt}, 64'd0);
        check("t6_rst_drop", {48'd0, drop_cnt}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 3'd0, 64'hF0F0);
        check("t6_stray_drop", {48'd0, drop_cnt}, 64'd1);
        check("t6_stray_nowrite", {63'd0, bus_if.out_val}, 64'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
